// File: rtl/sdram_device_responder.sv
// Device-side SDR SDRAM model: decodes controller command pins, tracks per-bank open rows,
// keeps data in on-chip RAM and returns read data after the programmed CAS latency.
//
// state       | meaning
// BANK_IDLE   | bank precharged, no row open; READ/WRITE rejected
// BANK_ACTIVE | row held in row_q, READ/WRITE allowed
module sdram_device_responder #(
  parameter int ROW_USED = 4,
  parameter int COL_USED = 6
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [12:0] sdram_addr,
  input  logic [1:0]  sdram_ba,
  input  logic        sdram_cs_n,
  input  logic        sdram_ras_n,
  input  logic        sdram_cas_n,
  input  logic        sdram_we_n,
  input  logic        sdram_cke,
  input  logic [3:0]  sdram_dqm,
  input  logic [31:0] sdram_dq_in,
  output logic [31:0] sdram_dq_out,
  output logic [3:0]  sdram_dq_oe,
  output logic        init_done,
  output logic [3:0]  err_flags,
  output logic [15:0] refresh_count
);
  localparam int AW    = 2 + ROW_USED + COL_USED;
  localparam int DEPTH = 1 << AW;

  typedef enum logic {BANK_IDLE, BANK_ACTIVE} bank_state_e;
  typedef enum logic [2:0] {
    CMD_LMR = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
    CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_BST = 3'b110, CMD_NOP = 3'b111
  } cmd_e;

  bank_state_e         bank_q [4];
  bank_state_e         bank_d [4];
  logic [ROW_USED-1:0] row_q  [4];
  logic [ROW_USED-1:0] row_d  [4];
  logic [1:0]          cl_q, cl_d;
  logic                init_q, init_d;
  logic [3:0]          err_q, err_d;
  logic [15:0]         ref_q, ref_d;
  logic                rd_go, wr_go, wr_cmd;
  logic                any_active;
  cmd_e                cmd;
  logic [AW-1:0]       acc_idx;
  logic [31:0]         mem [DEPTH];
  logic [31:0]         rd_word;
  logic [31:0]         pipe_data [3];
  logic [3:0]          pipe_mask [3];
  logic [2:0]          pipe_vld;
  logic                tail_vld;
  logic [31:0]         tail_data;
  logic [3:0]          tail_mask;
  logic                unused_addr;

  assign cmd = (sdram_cke && !sdram_cs_n) ? cmd_e'({sdram_ras_n, sdram_cas_n, sdram_we_n}) : CMD_NOP;
  assign any_active = (bank_q[0] == BANK_ACTIVE) || (bank_q[1] == BANK_ACTIVE) ||
                      (bank_q[2] == BANK_ACTIVE) || (bank_q[3] == BANK_ACTIVE);
  assign acc_idx = {sdram_ba, row_q[sdram_ba], sdram_addr[COL_USED-1:0]};
  assign rd_word = mem[acc_idx];
  assign unused_addr = ^sdram_addr;

  // Pipe stage CL-1 feeds the output register, so data appears CL cycles after the command
  assign tail_vld  = (cl_q == 2'd3) ? pipe_vld[2]  : pipe_vld[1];
  assign tail_data = (cl_q == 2'd3) ? pipe_data[2] : pipe_data[1];
  assign tail_mask = (cl_q == 2'd3) ? pipe_mask[2] : pipe_mask[1];

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      bank_d[b] = bank_q[b];
      row_d[b]  = row_q[b];
    end
    cl_d   = cl_q;
    init_d = init_q;
    err_d  = err_q;
    ref_d  = ref_q;
    rd_go  = 1'b0;
    wr_go  = 1'b0;
    wr_cmd = 1'b0;
    case (cmd)
      CMD_ACT: begin
        if (bank_q[sdram_ba] == BANK_ACTIVE) err_d[1] = 1'b1;
        bank_d[sdram_ba] = BANK_ACTIVE;
        row_d[sdram_ba]  = sdram_addr[ROW_USED-1:0];
      end
      CMD_PRE: begin
        if (sdram_addr[10]) begin
          for (int b = 0; b < 4; b++) bank_d[b] = BANK_IDLE;
        end else begin
          bank_d[sdram_ba] = BANK_IDLE;
        end
      end
      CMD_RD, CMD_WR: begin
        wr_cmd = (cmd == CMD_WR);
        if (!init_q) err_d[2] = 1'b1;
        if (bank_q[sdram_ba] == BANK_IDLE) err_d[0] = 1'b1;
        if (init_q && bank_q[sdram_ba] == BANK_ACTIVE) begin
          rd_go = (cmd == CMD_RD);
          wr_go = (cmd == CMD_WR);
          if (sdram_addr[10]) bank_d[sdram_ba] = BANK_IDLE;
        end
      end
      CMD_REF: begin
        if (any_active) err_d[3] = 1'b1;
        if (ref_q != 16'hFFFF) ref_d = ref_q + 16'd1;
      end
      CMD_LMR: begin
        if (!any_active && (sdram_addr[6:4] == 3'd2 || sdram_addr[6:4] == 3'd3) &&
            sdram_addr[2:0] == 3'd0) begin
          cl_d   = sdram_addr[5:4];
          init_d = 1'b1;
        end else begin
          err_d[2] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int b = 0; b < 4; b++) begin
        bank_q[b] <= BANK_IDLE;
        row_q[b]  <= '0;
      end
      for (int s = 0; s < 3; s++) begin
        pipe_data[s] <= '0;
        pipe_mask[s] <= '0;
      end
      pipe_vld      <= '0;
      cl_q          <= 2'd2;
      init_q        <= 1'b0;
      err_q         <= '0;
      ref_q         <= '0;
      sdram_dq_out  <= '0;
      sdram_dq_oe   <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        bank_q[b] <= bank_d[b];
        row_q[b]  <= row_d[b];
      end
      cl_q   <= cl_d;
      init_q <= init_d;
      err_q  <= err_d;
      ref_q  <= ref_d;
      pipe_data[0] <= rd_word;
      pipe_mask[0] <= sdram_dqm;
      for (int s = 1; s < 3; s++) begin
        pipe_data[s] <= pipe_data[s-1];
        pipe_mask[s] <= pipe_mask[s-1];
      end
      pipe_vld     <= {pipe_vld[1:0], rd_go};
      sdram_dq_out <= tail_data;
      sdram_dq_oe  <= tail_vld ? ~tail_mask : 4'h0;
      // Controller takes the bus for a write: every read still in flight is dropped
      if (wr_cmd) begin
        pipe_vld[2:1] <= 2'b00;
        sdram_dq_oe   <= 4'h0;
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (wr_go && !reset_reset) begin
      for (int k = 0; k < 4; k++) begin
        if (!sdram_dqm[k]) mem[acc_idx][8*k +: 8] <= sdram_dq_in[8*k +: 8];
      end
    end
  end

  assign init_done     = init_q;
  assign err_flags     = err_q;
  assign refresh_count = ref_q;
endmodule

// File: tb/tb_sdram_device_responder.sv
// Self-checking bench: directed scenarios plus random command streams checked against a
// cycle-indexed behavioural model (arrays of per-bank rows, word store, expected bus per cycle).
module tb_sdram_device_responder;
  localparam int ROW_USED = 4;
  localparam int COL_USED = 6;
  localparam int NCYC     = 2048;
  localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010, C_REF = 3'b001, C_LMR = 3'b000;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_ba;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_cke;
  logic [3:0]  sdram_dqm;
  logic [31:0] sdram_dq_in;
  logic [31:0] sdram_dq_out;
  logic [3:0]  sdram_dq_oe;
  logic        init_done;
  logic [3:0]  err_flags;
  logic [15:0] refresh_count;

  sdram_device_responder #(.ROW_USED(ROW_USED), .COL_USED(COL_USED)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .sdram_addr(sdram_addr), .sdram_ba(sdram_ba),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
    .sdram_we_n(sdram_we_n), .sdram_cke(sdram_cke), .sdram_dqm(sdram_dqm),
    .sdram_dq_in(sdram_dq_in), .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe),
    .init_done(init_done), .err_flags(err_flags), .refresh_count(refresh_count)
  );

  always #5 clk_clk = ~clk_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [3:0]  exp_oe [NCYC];
  logic [31:0] exp_dq [NCYC];
  logic [31:0] exp_m  [NCYC];
  logic [3:0]  obs_oe [NCYC];
  logic [31:0] obs_dq [NCYC];

  bit          m_open [4];
  int          m_row  [4];
  int          m_cl;
  bit          m_init;
  logic [3:0]  m_err;
  int          m_ref;
  logic [31:0] m_mem [int];
  logic [3:0]  m_kb  [int];

  task automatic clear_from(input int e);
    for (int c = e; c < e + 4; c++) begin
      exp_oe[c] = 4'h0;
      exp_m[c]  = '0;
    end
  endtask

  // Behavioural model: one command taking effect at edge e
  task automatic model_update(input bit rst, input bit cs_n, input bit cke, input logic [2:0] c,
                              input logic [1:0] ba, input logic [12:0] addr,
                              input logic [3:0] dqm, input logic [31:0] dq, input int e);
    int idx;
    logic [31:0] w;
    logic [3:0] kb;
    bit any_open;
    any_open = m_open[0] || m_open[1] || m_open[2] || m_open[3];
    if (rst) begin
      for (int b = 0; b < 4; b++) m_open[b] = 0;
      m_init = 0; m_err = 4'h0; m_ref = 0;
      clear_from(e);
    end else if (cke && !cs_n) begin
      case (c)
        C_ACT: begin
          if (m_open[ba]) m_err[1] = 1'b1;
          m_open[ba] = 1;
          m_row[ba]  = int'(addr) % (1 << ROW_USED);
        end
        C_PRE: begin
          if (addr[10]) for (int b = 0; b < 4; b++) m_open[b] = 0;
          else m_open[ba] = 0;
        end
        C_RD, C_WR: begin
          if (!m_init) m_err[2] = 1'b1;
          if (!m_open[ba]) m_err[0] = 1'b1;
          if (c == C_WR) clear_from(e);
          if (m_init && m_open[ba]) begin
            idx = int'(ba) * (1 << (ROW_USED + COL_USED)) + m_row[ba] * (1 << COL_USED) +
                  int'(addr) % (1 << COL_USED);
            w  = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
            kb = m_kb.exists(idx)  ? m_kb[idx]  : 4'h0;
            if (c == C_RD) begin
              exp_oe[e + m_cl] = ~dqm;
              exp_dq[e + m_cl] = w;
              for (int k = 0; k < 4; k++)
                exp_m[e + m_cl][8*k +: 8] = (!dqm[k] && kb[k]) ? 8'hFF : 8'h00;
            end else begin
              for (int k = 0; k < 4; k++) if (!dqm[k]) begin
                w[8*k +: 8] = dq[8*k +: 8];
                kb[k] = 1'b1;
              end
              m_mem[idx] = w;
              m_kb[idx]  = kb;
            end
            if (addr[10]) m_open[ba] = 0;
          end
        end
        C_REF: begin
          if (any_open) m_err[3] = 1'b1;
          if (m_ref < 65535) m_ref++;
        end
        C_LMR: begin
          if (!any_open && (addr[6:4] == 3'd2 || addr[6:4] == 3'd3) && addr[2:0] == 3'd0) begin
            m_cl = int'(addr[6:4]);
            m_init = 1;
          end else m_err[2] = 1'b1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic tick(input bit rst, input bit cs_n, input bit cke, input logic [2:0] c,
                      input logic [1:0] ba, input logic [12:0] addr,
                      input logic [3:0] dqm, input logic [31:0] dq);
    int e;
    e = cyc + 1;
    if (e + 4 >= NCYC) begin
      $display("FAIL cycle_budget: reached %0d, limit %0d", e, NCYC - 4);
      $fatal(1, "cycle budget exhausted");
    end
    reset_reset = rst; sdram_cs_n = cs_n; sdram_cke = cke;
    {sdram_ras_n, sdram_cas_n, sdram_we_n} = c;
    sdram_ba = ba; sdram_addr = addr; sdram_dqm = dqm; sdram_dq_in = dq;
    model_update(rst, cs_n, cke, c, ba, addr, dqm, dq, e);
    @(posedge clk_clk);
    #1;
    cyc = e;
    obs_oe[e] = sdram_dq_oe;
    obs_dq[e] = sdram_dq_out;
  endtask

  task automatic cmd(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] addr,
                     input logic [3:0] dqm = 4'h0, input logic [31:0] dq = 32'h0);
    tick(1'b0, 1'b0, 1'b1, c, ba, addr, dqm, dq);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 1'b1, C_NOP, 2'd0, 13'h0, 4'h0, 32'h0);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b1, 1'b1, C_NOP, 2'd0, 13'h0, 4'h0, 32'h0);
  endtask

  task automatic test_reset();
    int c0;
    do_reset(); do_reset();
    c0 = cyc;
    n_checks++; if (sdram_dq_oe !== 4'h0) begin n_fail++; $display("FAIL reset_oe: got %h want 0", sdram_dq_oe); end
    n_checks++; if (sdram_dq_out !== 32'h0) begin n_fail++; $display("FAIL reset_dq: got %h want 0", sdram_dq_out); end
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init: got %b want 0", init_done); end
    n_checks++; if (err_flags !== 4'h0) begin n_fail++; $display("FAIL reset_err: got %h want 0", err_flags); end
    n_checks++; if (refresh_count !== 16'h0) begin n_fail++; $display("FAIL reset_ref: got %h want 0", refresh_count); end
    nop(1);
    for (int c = c0 + 1; c <= cyc; c++) begin
      n_checks++;
      if (obs_oe[c] !== exp_oe[c]) begin n_fail++; $display("FAIL reset_bus c%0d: oe %h want %h", c, obs_oe[c], exp_oe[c]); end
    end
  endtask

  task automatic test_basic();
    int c0, r;
    c0 = cyc;
    cmd(C_LMR, 2'd0, 13'h020);
    cmd(C_ACT, 2'd1, 13'd3);
    cmd(C_WR, 2'd1, 13'd5, 4'h0, 32'hDEADBEEF);
    cmd(C_RD, 2'd1, 13'd5); r = cyc;
    nop(4);
    n_checks++; if (obs_oe[r+1] !== 4'h0) begin n_fail++; $display("FAIL basic_early: oe %h want 0", obs_oe[r+1]); end
    n_checks++; if (obs_oe[r+2] !== 4'hF || obs_dq[r+2] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL basic_read: oe %h dq %h want F DEADBEEF", obs_oe[r+2], obs_dq[r+2]); end
    n_checks++; if (obs_oe[r+3] !== 4'h0) begin n_fail++; $display("FAIL basic_late: oe %h want 0", obs_oe[r+3]); end
    n_checks++; if (err_flags !== 4'h0 || init_done !== 1'b1) begin
      n_fail++; $display("FAIL basic_status: err %h init %b want 0 1", err_flags, init_done); end
    for (int c = c0 + 1; c <= cyc; c++) begin
      n_checks++;
      if (obs_oe[c] !== exp_oe[c] || (obs_dq[c] & exp_m[c]) !== (exp_dq[c] & exp_m[c])) begin
        n_fail++; $display("FAIL basic_bus c%0d: oe %h dq %h want %h %h", c, obs_oe[c], obs_dq[c], exp_oe[c], exp_dq[c]); end
    end
  endtask

  task automatic test_cl3_back_to_back();
    int c0, r;
    logic [31:0] words [4];
    c0 = cyc;
    cmd(C_PRE, 2'd0, 13'h400);
    cmd(C_LMR, 2'd0, 13'h030);
    cmd(C_ACT, 2'd1, 13'd3);
    for (int i = 0; i < 4; i++) begin
      words[i] = $urandom;
      cmd(C_WR, 2'd1, 13'(20 + i), 4'h0, words[i]);
    end
    for (int i = 0; i < 4; i++) cmd(C_RD, 2'd1, 13'(20 + i));
    r = cyc - 3;
    nop(5);
    n_checks++; if (obs_oe[r+2] !== 4'h0) begin n_fail++; $display("FAIL cl3_early: oe %h want 0", obs_oe[r+2]); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs_oe[r+3+i] !== 4'hF || obs_dq[r+3+i] !== words[i]) begin
        n_fail++; $display("FAIL cl3_word%0d: oe %h dq %h want F %h", i, obs_oe[r+3+i], obs_dq[r+3+i], words[i]); end
    end
    n_checks++; if (obs_oe[r+7] !== 4'h0) begin n_fail++; $display("FAIL cl3_late: oe %h want 0", obs_oe[r+7]); end
    for (int c = c0 + 1; c <= cyc; c++) begin
      n_checks++;
      if (obs_oe[c] !== exp_oe[c] || (obs_dq[c] & exp_m[c]) !== (exp_dq[c] & exp_m[c])) begin
        n_fail++; $display("FAIL cl3_bus c%0d: oe %h dq %h want %h %h", c, obs_oe[c], obs_dq[c], exp_oe[c], exp_dq[c]); end
    end
  endtask

  task automatic test_dqm();
    int c0, r0, r1;
    c0 = cyc;
    cmd(C_WR, 2'd1, 13'd7, 4'h0, 32'hAAAAAAAA);
    cmd(C_WR, 2'd1, 13'd7, 4'b0101, 32'h11223344);
    cmd(C_RD, 2'd1, 13'd7); r0 = cyc;
    nop(4);
    cmd(C_RD, 2'd1, 13'd7, 4'b1000); r1 = cyc;
    nop(4);
    n_checks++; if (obs_oe[r0+3] !== 4'hF || obs_dq[r0+3] !== 32'h11AA33AA) begin
      n_fail++; $display("FAIL dqm_write: oe %h dq %h want F 11AA33AA", obs_oe[r0+3], obs_dq[r0+3]); end
    n_checks++; if (obs_oe[r1+3] !== 4'b0111 || obs_dq[r1+3][23:0] !== 24'hAA33AA) begin
      n_fail++; $display("FAIL dqm_read: oe %h dq %h want 7 xxAA33AA", obs_oe[r1+3], obs_dq[r1+3]); end
    for (int c = c0 + 1; c <= cyc; c++) begin
      n_checks++;
      if (obs_oe[c] !== exp_oe[c] || (obs_dq[c] & exp_m[c]) !== (exp_dq[c] & exp_m[c])) begin
        n_fail++; $display("FAIL dqm_bus c%0d: oe %h dq %h want %h %h", c, obs_oe[c], obs_dq[c], exp_oe[c], exp_dq[c]); end
    end
  endtask

  task automatic test_errors();
    int c0;
    c0 = cyc;
    cmd(C_RD, 2'd2, 13'd0);
    nop(4);
    n_checks++; if (err_flags !== 4'b0001) begin n_fail++; $display("FAIL err_idle_read: err %h want 1", err_flags); end
    cmd(C_ACT, 2'd0, 13'd1);
    cmd(C_ACT, 2'd0, 13'd2);
    n_checks++; if (err_flags !== 4'b0011) begin n_fail++; $display("FAIL err_double_act: err %h want 3", err_flags); end
    for (int c = c0 + 1; c <= cyc; c++) begin
      n_checks++;
      if (obs_oe[c] !== exp_oe[c]) begin n_fail++; $display("FAIL err_bus c%0d: oe %h want %h", c, obs_oe[c], exp_oe[c]); end
    end
    do_reset();
    cmd(C_LMR, 2'd0, 13'h021);
    n_checks++; if (err_flags !== 4'b0100 || init_done !== 1'b0) begin
      n_fail++; $display("FAIL err_bad_lmr: err %h init %b want 4 0", err_flags, init_done); end
  endtask

  task automatic test_turnaround();
    int c0, r, r2;
    do_reset();
    c0 = cyc;
    cmd(C_LMR, 2'd0, 13'h020);
    cmd(C_ACT, 2'd3, 13'd9);
    cmd(C_WR, 2'd3, 13'd2, 4'h0, 32'h01020304);
    cmd(C_RD, 2'd3, 13'd2); r = cyc;
    cmd(C_WR, 2'd3, 13'd2, 4'h0, 32'h55667788);
    nop(3);
    cmd(C_RD, 2'd3, 13'd2); r2 = cyc;
    nop(3);
    n_checks++; if (obs_oe[r+1] !== 4'h0 || obs_oe[r+2] !== 4'h0 || obs_oe[r+3] !== 4'h0) begin
      n_fail++; $display("FAIL turn_cancel: oe %h %h %h want 0 0 0", obs_oe[r+1], obs_oe[r+2], obs_oe[r+3]); end
    n_checks++; if (obs_oe[r2+2] !== 4'hF || obs_dq[r2+2] !== 32'h55667788) begin
      n_fail++; $display("FAIL turn_write: oe %h dq %h want F 55667788", obs_oe[r2+2], obs_dq[r2+2]); end
    for (int c = c0 + 1; c <= cyc; c++) begin
      n_checks++;
      if (obs_oe[c] !== exp_oe[c] || (obs_dq[c] & exp_m[c]) !== (exp_dq[c] & exp_m[c])) begin
        n_fail++; $display("FAIL turn_bus c%0d: oe %h dq %h want %h %h", c, obs_oe[c], obs_dq[c], exp_oe[c], exp_dq[c]); end
    end
  endtask

  task automatic test_refresh_reset();
    int c0, r, r2;
    do_reset();
    c0 = cyc;
    cmd(C_LMR, 2'd0, 13'h020);
    cmd(C_ACT, 2'd0, 13'd5);
    for (int i = 0; i < 3; i++) cmd(C_REF, 2'd0, 13'h0);
    n_checks++; if (refresh_count !== 16'd3 || err_flags !== 4'b1000) begin
      n_fail++; $display("FAIL refresh: count %0d err %h want 3 8", refresh_count, err_flags); end
    cmd(C_WR, 2'd0, 13'd9, 4'h0, 32'hCAFEF00D);
    cmd(C_RD, 2'd0, 13'd9); r = cyc;
    do_reset();
    n_checks++; if (sdram_dq_oe !== 4'h0 || sdram_dq_out !== 32'h0 || init_done !== 1'b0 ||
                    err_flags !== 4'h0 || refresh_count !== 16'h0) begin
      n_fail++; $display("FAIL midread_reset: oe %h dq %h init %b err %h ref %0d want all 0",
                         sdram_dq_oe, sdram_dq_out, init_done, err_flags, refresh_count); end
    nop(2);
    n_checks++; if (obs_oe[r+2] !== 4'h0) begin n_fail++; $display("FAIL midread_drop: oe %h want 0", obs_oe[r+2]); end
    cmd(C_LMR, 2'd0, 13'h020);
    cmd(C_ACT, 2'd0, 13'd5);
    cmd(C_RD, 2'd0, 13'd9); r2 = cyc;
    nop(3);
    n_checks++; if (obs_oe[r2+2] !== 4'hF || obs_dq[r2+2] !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL retained: oe %h dq %h want F CAFEF00D", obs_oe[r2+2], obs_dq[r2+2]); end
    for (int c = c0 + 1; c <= cyc; c++) begin
      n_checks++;
      if (obs_oe[c] !== exp_oe[c] || (obs_dq[c] & exp_m[c]) !== (exp_dq[c] & exp_m[c])) begin
        n_fail++; $display("FAIL refresh_bus c%0d: oe %h dq %h want %h %h", c, obs_oe[c], obs_dq[c], exp_oe[c], exp_dq[c]); end
    end
  endtask

  task automatic test_random();
    int c0, last_rd, sel;
    logic [12:0] lmr_addr [5];
    lmr_addr[0] = 13'h020; lmr_addr[1] = 13'h030; lmr_addr[2] = 13'h021;
    lmr_addr[3] = 13'h040; lmr_addr[4] = 13'h420;
    do_reset();
    c0 = cyc;
    cmd(C_LMR, 2'd0, 13'h020);
    last_rd = cyc;
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 20) tick(1'b0, 1'($urandom), 1'($urandom), 3'($urandom), 2'($urandom), 13'($urandom), 4'h0, 32'h0);
      else if (sel < 45) begin
        cmd(C_RD, 2'($urandom), 13'($urandom), 4'($urandom));
        last_rd = cyc;
      end
      else if (sel < 65) cmd(C_WR, 2'($urandom), 13'($urandom), 4'($urandom), $urandom);
      else if (sel < 80) cmd(C_ACT, 2'($urandom), 13'($urandom));
      else if (sel < 90) cmd(C_PRE, 2'($urandom), 13'($urandom));
      else if (sel < 94) cmd(C_REF, 2'd0, 13'h0);
      else if (cyc - last_rd > 4) cmd(C_LMR, 2'd0, lmr_addr[$urandom_range(0, 4)]);
      else nop(1);
    end
    nop(5);
    for (int c = c0 + 1; c <= cyc; c++) begin
      n_checks++;
      if (obs_oe[c] !== exp_oe[c] || (obs_dq[c] & exp_m[c]) !== (exp_dq[c] & exp_m[c])) begin
        n_fail++; $display("FAIL random_bus c%0d: oe %h dq %h want %h %h", c, obs_oe[c], obs_dq[c], exp_oe[c], exp_dq[c]); end
    end
    n_checks++; if (err_flags !== m_err) begin n_fail++; $display("FAIL random_err: got %h want %h", err_flags, m_err); end
    n_checks++; if (init_done !== m_init) begin n_fail++; $display("FAIL random_init: got %b want %b", init_done, m_init); end
    n_checks++; if (int'(refresh_count) != m_ref) begin n_fail++; $display("FAIL random_ref: got %0d want %0d", refresh_count, m_ref); end
  endtask

  initial begin
    for (int c = 0; c < NCYC; c++) begin
      exp_oe[c] = 4'h0; exp_dq[c] = '0; exp_m[c] = '0;
      obs_oe[c] = 4'h0; obs_dq[c] = '0;
    end
    for (int b = 0; b < 4; b++) begin m_open[b] = 0; m_row[b] = 0; end
    m_cl = 2; m_init = 0; m_err = 4'h0; m_ref = 0;
    test_reset();
    test_basic();
    test_cl3_back_to_back();
    test_dqm();
    test_errors();
    test_turnaround();
    test_refresh_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_device_responder.md
Name: sdram_device_responder

Overview:
- Synthesizable device-side model of the 32-bit SDR SDRAM attached to the Qsys SDRAM controller. It decodes the sdram_* command pins, tracks per-bank open rows, stores data in an on-chip RAM and returns read data after the programmed CAS latency.
- It replaces the external chip in simulation and in the loopback build, so the controller and VGA frame-buffer traffic can be checked without board memory.

Parameters:
- ROW_USED, 4, low row-address bits kept in storage.
- COL_USED, 6, low column-address bits kept in storage.
- Storage depth is 2^(2+ROW_USED+COL_USED) 32-bit words. The index is {ba, row[ROW_USED-1:0], col[COL_USED-1:0]}.

Ports:
- clk_clk  in  1  device clock, same as controller clock
- reset_reset  in  1  synchronous, active-high reset
- sdram_addr  in  13  row / column / mode address
- sdram_ba  in  2  bank select
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  in  1 each  command pins
- sdram_cke  in  1  clock enable
- sdram_dqm  in  4  byte masks
- sdram_dq_in  in  32  write data from controller
- sdram_dq_out  out  32  read data
- sdram_dq_oe  out  4  per-byte output enable; top level builds the tristate
- init_done  out  1  set by the first legal LOAD MODE
- err_flags  out  4  sticky protocol errors
- refresh_count  out  16  saturating count of AUTO REFRESH commands

Behaviour:
- Reset values: dq_out=0, dq_oe=0, init_done=0, err_flags=0, refresh_count=0. Reset also sets all banks idle, mode invalid and the read pipe empty. Memory contents are not cleared. Reset mid-read drops the pending data.
- Command decode is registered on the rising edge and valid only when cke=1 and cs_n=0. cke=0 or cs_n=1 means NOP; the read pipe keeps advancing. Decode on {ras_n,cas_n,we_n}:
  - 111 NOP
  - 011 ACTIVE
  - 101 READ
  - 100 WRITE
  - 010 PRECHARGE
  - 001 AUTO REFRESH
  - 000 LOAD MODE
  - 110 BURST TERMINATE, treated as NOP
- Per-bank state machine, states IDLE and ACTIVE(row):
  - ACTIVE on an IDLE bank: go ACTIVE, latch addr as the row.
  - ACTIVE on an ACTIVE bank: set err[1], replace the row.
  - PRECHARGE: addr[10]=1 idles all banks; otherwise idles bank ba.
  - READ or WRITE with addr[10]=1 (auto-precharge): bank goes IDLE after the access.
- LOAD MODE:
  - Legal only when all banks are IDLE, addr[6:4] in {2,3} (CAS latency) and addr[2:0]=0 (burst length 1). Legal: latch CL, set init_done.
  - Otherwise set err[2]; mode and init_done are unchanged.
- WRITE:
  - Writes dq_in to the word at {ba, open row, addr[COL_USED-1:0]} in the same edge.
  - A byte is written only where dqm bit=0.
- READ:
  - Data is driven exactly CL cycles after the command edge. With CL=2: command at edge n, dq_out valid and dq_oe asserted during cycle n+2, for one cycle.
  - Bytes whose dqm bit was 1 at the command edge get dq_oe bit 0.
  - Back-to-back READs give back-to-back data, with no bubbles.
  - Implement as a CL-deep shift pipe carrying data, mask and valid.
- Read/write ordering:
  - A WRITE issued while read data is still in the pipe cancels all pending read slots (bus turnaround). Those slots never assert dq_oe.
  - A READ to an address written one edge earlier returns the new data.
- Error flags (sticky until reset):
  - err[0]: READ/WRITE to an IDLE bank. Access is ignored; no data is driven.
  - err[1]: ACTIVE to an ACTIVE bank.
  - err[2]: illegal LOAD MODE, or READ/WRITE before init_done. Access is ignored.
  - err[3]: AUTO REFRESH while any bank is ACTIVE. Still counted.
- refresh_count increments on each AUTO REFRESH and saturates at 0xFFFF.
- Column/row bits above COL_USED/ROW_USED are ignored, so addresses alias.

Test Plan:
- LOAD MODE addr=0x020, ACTIVE ba=1 row=3, WRITE col=5 dq=0xDEADBEEF dqm=0, READ col=5 -> dq_out=0xDEADBEEF with dq_oe=0xF exactly 2 cycles after READ; err_flags=0.
- Mode CL=3 (addr=0x030), 4 back-to-back READs of preloaded words -> data on 4 consecutive cycles starting 3 cycles after the first READ.
- WRITE 0x11223344 with dqm=0b0101 over 0xAAAAAAAA -> read returns 0x11AA33AA. READ with dqm=0b1000 -> dq_oe=0b0111.
- READ to idle bank 2 -> err[0]=1, no dq_oe. ACTIVE twice on bank 0 -> err[1]=1. LOAD MODE with addr[2:0]=1 -> err[2]=1, init_done stays 0.
- READ then WRITE on the next cycle (CL=2) -> the read slot never asserts dq_oe, and the write lands.
- 3 AUTO REFRESH with bank 0 active -> refresh_count=3, err[3]=1. Reset asserted mid-read pipe -> dq_oe=0 next cycle, all outputs at reset values, and previously written data is still readable after re-init.
